// File: rtl/cam_buf_pkg.sv
// Shared defaults and capture state encoding for the frame buffer controller.
package cam_buf_pkg;

    localparam int DEF_AW           = 17;
    localparam int DEF_DW           = 16;
    localparam int DEF_FRAME_PIXELS = 76800;  // 320 x 240

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/frame_buffer_ctrl_if.sv
// Frame RAM bus: one registered write port and one single-cycle-latency read port.
interface frame_buffer_ctrl_if
    import cam_buf_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic [AW-1:0] ram_addr_in;
    logic [DW-1:0] ram_data_in;
    logic          ram_regwrite;
    logic [AW-1:0] ram_addr_out;
    logic          ram_regread;
    logic [DW-1:0] ram_data_out;

    // Controller side drives addresses/strobes, RAM side returns read data.
    modport master (
        output ram_addr_in, ram_data_in, ram_regwrite,
        output ram_addr_out, ram_regread,
        input  ram_data_out
    );

    modport slave (
        input  ram_addr_in, ram_data_in, ram_regwrite,
        input  ram_addr_out, ram_regread,
        output ram_data_out
    );
endinterface

// File: rtl/fb_rd_arbiter.sv
// Read-port arbiter: display has strict priority, host is locked out while a
// capture is in progress. Valids trail the grant by the one-cycle RAM latency.
module fb_rd_arbiter
    import cam_buf_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cap_busy,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    input  logic          host_req,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] ram_data_out,
    output logic [AW-1:0] ram_addr_out,
    output logic          ram_regread,
    output logic          host_gnt,
    output logic          disp_valid,
    output logic [DW-1:0] disp_data,
    output logic          host_valid,
    output logic [DW-1:0] host_data
);
    logic          disp_gnt;
    logic [AW-1:0] addr_hold;

    // Grants are combinational so a request is serviced in its own cycle;
    // rst masks them so every output reads zero while reset is held.
    assign disp_gnt     = disp_req & ~rst;
    assign host_gnt     = host_req & ~disp_req & ~cap_busy & ~rst;
    assign ram_regread  = disp_gnt | host_gnt;
    assign ram_addr_out = disp_gnt ? disp_addr :
                          host_gnt ? host_addr : addr_hold;

    // Data is only passed through while its valid is high, zero otherwise.
    assign disp_data = disp_valid ? ram_data_out : '0;
    assign host_data = host_valid ? ram_data_out : '0;

    // Remember the last driven address and delay grants to line up with RAM data.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_hold  <= '0;
            disp_valid <= 1'b0;
            host_valid <= 1'b0;
        end else begin
            addr_hold  <= ram_addr_out;
            disp_valid <= disp_gnt;
            host_valid <= host_gnt;
        end
    end

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Camera frame capture into RAM plus shared read access for display and host.
module frame_buffer_ctrl
    import cam_buf_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int FRAME_PIXELS = DEF_FRAME_PIXELS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cap_start,
    input  logic                cam_vsync,
    input  logic                cam_pix_valid,
    input  logic [DW-1:0]       cam_pix_data,
    output logic                cap_busy,
    output logic                cap_done,
    output logic                cap_err,
    frame_buffer_ctrl_if.master ram,
    input  logic                disp_req,
    input  logic [AW-1:0]       disp_addr,
    output logic                disp_valid,
    output logic [DW-1:0]       disp_data,
    input  logic                host_req,
    input  logic [AW-1:0]       host_addr,
    output logic                host_gnt,
    output logic                host_valid,
    output logic [DW-1:0]       host_data
);
    cap_state_t    state;
    logic          vsync_q;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;
    logic          vsync_rise;
    logic          restart;
    logic [AW-1:0] cur_addr;
    logic          last_pix;
    logic [AW-1:0] rd_addr;
    logic          rd_en;

    assign vsync_rise = cam_vsync & ~vsync_q;
    // A vsync edge mid-frame restarts at 0; a pixel in that same cycle is
    // treated as the first pixel of the new frame.
    assign restart    = (state == ST_CAPTURE) && vsync_rise;
    assign cur_addr   = restart ? '0 : wr_addr;
    assign last_pix   = (cur_addr == AW'(FRAME_PIXELS - 1));

    assign ram.ram_regwrite = wr_en;
    assign ram.ram_addr_in  = wr_addr_q;
    assign ram.ram_data_in  = wr_data_q;
    assign ram.ram_addr_out = rd_addr;
    assign ram.ram_regread  = rd_en;

    // Capture FSM with registered status and write-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            vsync_q   <= 1'b0;
            wr_addr   <= '0;
            wr_en     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cap_busy  <= 1'b0;
            cap_done  <= 1'b0;
            cap_err   <= 1'b0;
        end else begin
            vsync_q  <= cam_vsync;
            wr_en    <= 1'b0;
            cap_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cap_start) begin
                        state    <= ST_ARMED;
                        cap_busy <= 1'b1;
                        cap_err  <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (vsync_rise) begin
                        state   <= ST_CAPTURE;
                        wr_addr <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (restart) begin
                        cap_err <= 1'b1;
                        wr_addr <= '0;
                    end
                    if (cam_pix_valid) begin
                        wr_en     <= 1'b1;
                        wr_addr_q <= cur_addr;
                        wr_data_q <= cam_pix_data;
                        if (last_pix) begin
                            state    <= ST_DONE;
                            cap_busy <= 1'b0;
                        end else begin
                            wr_addr <= cur_addr + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    cap_done <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fb_rd_arbiter #(
        .AW (AW),
        .DW (DW)
    ) u_rd_arbiter (
        .clk          (clk),
        .rst          (rst),
        .cap_busy     (cap_busy),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .host_req     (host_req),
        .host_addr    (host_addr),
        .ram_data_out (ram.ram_data_out),
        .ram_addr_out (rd_addr),
        .ram_regread  (rd_en),
        .host_gnt     (host_gnt),
        .disp_valid   (disp_valid),
        .disp_data    (disp_data),
        .host_valid   (host_valid),
        .host_data    (host_data)
    );

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl with a behavioural 1-cycle-latency RAM.
module tb_frame_buffer_ctrl;
    localparam int AW = 17;
    localparam int DW = 16;
    localparam int FP = 76800;

    logic          clk = 1'b0;
    logic          rst;
    logic          cap_start;
    logic          cam_vsync;
    logic          cam_pix_valid;
    logic [DW-1:0] cam_pix_data;
    logic          cap_busy, cap_done, cap_err;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_valid;
    logic [DW-1:0] disp_data;
    logic          host_req;
    logic [AW-1:0] host_addr;
    logic          host_gnt, host_valid;
    logic [DW-1:0] host_data;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    frame_buffer_ctrl_if #(.AW(AW), .DW(DW)) ram_bus ();

    frame_buffer_ctrl #(.AW(AW), .DW(DW), .FRAME_PIXELS(FP)) dut (
        .clk           (clk),
        .rst           (rst),
        .cap_start     (cap_start),
        .cam_vsync     (cam_vsync),
        .cam_pix_valid (cam_pix_valid),
        .cam_pix_data  (cam_pix_data),
        .cap_busy      (cap_busy),
        .cap_done      (cap_done),
        .cap_err       (cap_err),
        .ram           (ram_bus),
        .disp_req      (disp_req),
        .disp_addr     (disp_addr),
        .disp_valid    (disp_valid),
        .disp_data     (disp_data),
        .host_req      (host_req),
        .host_addr     (host_addr),
        .host_gnt      (host_gnt),
        .host_valid    (host_valid),
        .host_data     (host_data)
    );

    always #5 clk = ~clk;

    // RAM model: write on strobe, read data one cycle after regread.
    initial ram_bus.ram_data_out = '0;
    always @(posedge clk) begin
        if (ram_bus.ram_regwrite) mem[ram_bus.ram_addr_in] <= ram_bus.ram_data_in;
        if (ram_bus.ram_regread)  ram_bus.ram_data_out <= mem[ram_bus.ram_addr_out];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vsync_pulse();
        cam_vsync = 1'b1;
        tick();
        cam_vsync = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input int addr, input logic [DW-1:0] data);
        chk(tag, 64'({ram_bus.ram_regwrite, ram_bus.ram_addr_in, ram_bus.ram_data_in}),
                 64'({1'b1, AW'(addr), data}));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   64'(cap_busy), 64'(0));
        chk({tag, "_done"},   64'(cap_done), 64'(0));
        chk({tag, "_err"},    64'(cap_err), 64'(0));
        chk({tag, "_wport"},  64'({ram_bus.ram_regwrite, ram_bus.ram_addr_in, ram_bus.ram_data_in}), 64'(0));
        chk({tag, "_rport"},  64'({ram_bus.ram_regread, ram_bus.ram_addr_out}), 64'(0));
        chk({tag, "_gnt"},    64'(host_gnt), 64'(0));
        chk({tag, "_disp"},   64'({disp_valid, disp_data}), 64'(0));
        chk({tag, "_host"},   64'({host_valid, host_data}), 64'(0));
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #1_500_000;
        $display("FAIL timeout vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cap_start = 1'b0; cam_vsync = 1'b0; cam_pix_valid = 1'b0;
        cam_pix_data = '0; disp_req = 1'b0; disp_addr = '0; host_req = 1'b0; host_addr = '0;
        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;

        // Pixels while idle or armed are not written.
        cam_pix_valid = 1'b1; cam_pix_data = 16'h1111;
        tick();
        chk("idle_nowrite", 64'(ram_bus.ram_regwrite), 64'(0));
        cam_pix_valid = 1'b0;
        cap_start = 1'b1;
        tick();
        cap_start = 1'b0;
        chk("armed_busy", 64'({cap_busy, cap_err}), 64'(2'b10));
        cam_pix_valid = 1'b1;
        tick();
        chk("armed_nowrite", 64'(ram_bus.ram_regwrite), 64'(0));
        cam_pix_valid = 1'b0;

        // Host requests throughout the capture; it must stay locked out.
        host_req = 1'b1; host_addr = '0;
        vsync_pulse();
        chk("cap_busy", 64'(cap_busy), 64'(1));

        // 100 pixels, then an early vsync restarts the frame.
        for (int n = 0; n < 100; n++) begin
            cam_pix_valid = 1'b1; cam_pix_data = DW'(234 + n);
            tick();
            chk_wr("pre_wr", n, DW'(234 + n));
        end
        cam_pix_valid = 1'b0;
        vsync_pulse();
        chk("restart_err", 64'({cap_err, cap_busy, ram_bus.ram_regwrite}), 64'(3'b110));

        // Full frame from address 0, with a display burst in the middle.
        for (int n = 0; n < FP; n++) begin
            cam_pix_valid = 1'b1; cam_pix_data = DW'(234 + n);
            disp_req  = (n >= 1000 && n < 1100);
            disp_addr = AW'(n - 1000);
            #1;
            if (n == 0)    chk("restart_addr0_gnt", 64'(host_gnt), 64'(0));
            if (n == 500)  chk("cap_host_locked", 64'({host_gnt, ram_bus.ram_regread}), 64'(0));
            if (n == 1050) chk("cap_disp_rd", 64'({host_gnt, ram_bus.ram_regread, ram_bus.ram_addr_out}),
                               64'({1'b0, 1'b1, AW'(50)}));
            if (n == 1200) chk("rd_addr_hold", 64'({ram_bus.ram_regread, ram_bus.ram_addr_out}),
                               64'({1'b0, AW'(99)}));
            tick();
            chk_wr("frame_wr", n, DW'(234 + n));
            if (n >= 1000 && n < 1100)
                chk("cap_disp_valid", 64'({disp_valid, disp_data}), 64'({1'b1, DW'(234 + n - 1000)}));
            if (n == 1100)
                chk("disp_idle_zero", 64'({disp_valid, disp_data}), 64'(0));
            if (n == 76799)
                chk("last_wr_status", 64'({cap_busy, cap_done}), 64'(0));
        end
        cam_pix_valid = 1'b0; disp_req = 1'b0;
        tick();
        chk("cap_done_pulse", 64'({cap_done, ram_bus.ram_regwrite, cap_err, cap_busy}), 64'(4'b1010));
        chk("host_gnt_after", 64'(host_gnt), 64'(1));
        tick();
        chk("cap_done_clear", 64'(cap_done), 64'(0));
        chk("host_read0", 64'({host_valid, host_data}), 64'({1'b1, DW'(234)}));
        host_req = 1'b0;

        // Display beats host when both request.
        disp_req = 1'b1; disp_addr = AW'(5); host_req = 1'b1; host_addr = AW'(9);
        #1;
        chk("prio_gnt", 64'({host_gnt, ram_bus.ram_regread, ram_bus.ram_addr_out}), 64'({1'b0, 1'b1, AW'(5)}));
        tick();
        chk("prio_disp", 64'({disp_valid, disp_data}), 64'({1'b1, DW'(239)}));
        chk("prio_host", 64'({host_valid, host_data}), 64'(0));
        disp_req = 1'b0;
        #1;
        chk("host_gnt_addr", 64'({host_gnt, ram_bus.ram_addr_out}), 64'({1'b1, AW'(9)}));
        tick();
        chk("host_read9", 64'({host_valid, host_data, disp_valid}), 64'({1'b1, DW'(243), 1'b0}));
        host_req = 1'b0;
        tick();
        chk("host_valid_drop", 64'({host_valid, host_data}), 64'(0));

        // Back-to-back display reads, one per cycle.
        for (int a = 0; a < 150; a++) begin
            disp_req = 1'b1; disp_addr = AW'(a);
            tick();
            chk("burst_rd", 64'({disp_valid, disp_data}), 64'({1'b1, DW'(234 + a)}));
        end
        disp_req = 1'b0;

        // New capture clears the sticky error; reset after 50 pixels aborts it.
        cap_start = 1'b1;
        tick();
        cap_start = 1'b0;
        chk("err_cleared", 64'({cap_err, cap_busy}), 64'(2'b01));
        vsync_pulse();
        for (int n = 0; n < 50; n++) begin
            cam_pix_valid = 1'b1; cam_pix_data = DW'(16'h5000 + n);
            tick();
            chk_wr("abort_wr", n, DW'(16'h5000 + n));
        end
        cam_pix_data = 16'hDEAD;
        rst = 1'b1; host_req = 1'b1; disp_req = 1'b1; host_addr = AW'(7); disp_addr = AW'(3);
        tick();
        chk_all_zero("midrst");
        rst = 1'b0; host_req = 1'b0; disp_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cam_vsync = (k == 2);
            tick();
            chk("post_rst_nowrite", 64'({ram_bus.ram_regwrite, cap_busy}), 64'(0));
        end
        cam_vsync = 1'b0; cam_pix_valid = 1'b0;
        cap_start = 1'b1;
        tick();
        cap_start = 1'b0;
        vsync_pulse();
        cam_pix_valid = 1'b1; cam_pix_data = 16'h7777;
        tick();
        chk_wr("recapture_wr", 0, 16'h7777);
        cam_pix_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
